// File: rtl/codec_ctrl_spi_slave.sv
// SPI responder for the codec control port: shifts in 16-bit {addr, data} words on
// spi_sck while cs is low, commits them on cs rising into a small register file.
module codec_ctrl_spi_slave #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 9,
    parameter int NUM_REGS    = 10,
    parameter int RESET_ADDR  = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    input  logic              cs,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              soft_rst,
    output logic              frame_err,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [7:0]        frame_cnt,
    output logic [1:0]        dbg_state
);

    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [CNT_W-1:0]  CNT_FULL     = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT      = CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W-1:0] NUM_REGS_A   = ADDR_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] RESET_ADDR_A = ADDR_W'(RESET_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q;
    logic                   sck_prev_q, cs_prev_q;
    logic [SYNC_STAGES:0]   vld_q;
    logic                   sck_rise_q, cs_rise_q, cs_fall_q, mosi_q;
    logic                   sck_s, cs_s, mosi_s, edge_ok;

    assign sck_s   = sck_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    // Strobes stay quiet until the compare flop holds a real sample, so a frame
    // already running at reset release cannot produce a false cs_fall.
    assign edge_ok = vld_q[SYNC_STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            vld_q       <= '0;
            sck_rise_q  <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sck_sync_q  <= SYNC_STAGES'({sck_sync_q, spi_sck});
            mosi_sync_q <= SYNC_STAGES'({mosi_sync_q, spi_mosi});
            cs_sync_q   <= SYNC_STAGES'({cs_sync_q, cs});
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            vld_q       <= {vld_q[SYNC_STAGES-1:0], 1'b1};
            sck_rise_q  <= edge_ok & sck_s & ~sck_prev_q;
            cs_rise_q   <= edge_ok & cs_s & ~cs_prev_q;
            cs_fall_q   <= edge_ok & ~cs_s & cs_prev_q;
            mosi_q      <= mosi_s;
        end
    end

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall_q || pend_q) begin
                    state_d = ST_SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                // A bit arriving together with cs_rise still belongs to the frame.
                if (sck_rise_q) begin
                    shift_d = {shift_q[FRAME_W-2:0], mosi_q};
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
                end
                if (cs_rise_q) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (cs_fall_q) pend_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic              commit_q, commit_ok;
    logic [ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0] commit_data;

    assign commit_q    = (state_q == ST_COMMIT);
    assign commit_ok   = commit_q && (cnt_q == CNT_FULL);
    assign commit_addr = shift_q[FRAME_W-1 -: ADDR_W];
    assign commit_data = shift_q[DATA_W-1:0];

    logic              wr_valid_q, soft_rst_q, frame_err_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [7:0]        frame_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_valid_q  <= 1'b0;
            soft_rst_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            wr_valid_q  <= commit_ok;
            soft_rst_q  <= commit_ok && (commit_addr == RESET_ADDR_A);
            frame_err_q <= commit_q && !commit_ok;
            if (commit_ok) begin
                wr_addr_q   <= commit_addr;
                wr_data_q   <= commit_data;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (commit_ok) begin
            if (commit_addr == RESET_ADDR_A) begin
                for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            end else if (commit_addr < NUM_REGS_A) begin
                regs_q[commit_addr[IDX_W-1:0]] <= commit_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (rd_addr < NUM_REGS_A) begin
            rd_data_q <= regs_q[rd_addr[IDX_W-1:0]];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign soft_rst  = soft_rst_q;
    assign frame_err = frame_err_q;
    assign rd_data   = rd_data_q;
    assign frame_cnt = frame_cnt_q;
    assign dbg_state = state_q;

endmodule
